mem_wb_stage: RTL and testbench

- MEM/WB pipeline register of the 5-stage pipelined RISC-V core.
- Captures MEM-stage results, including the raw data-memory word, and aligns and sign-extends load data at capture.
- Presents registered operands to the downstream writeback data-select mux (memData, aluOut, PC, imm, 3-bit select) and the register-file write control.
- Supports stall and flush from the hazard unit, flags misaligned loads, and counts retired instructions.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/load_align.sv | 46 ++++
 rtl/mem_wb_stage.sv | 104 ++++++++++
 tb/tb_mem_wb_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: writeback select codes and load funct3 encodings.
package riscv_pkg;

   typedef enum logic [2:0] {
      WB_PC4   = 3'b000,
      WB_ALU   = 3'b001,
      WB_AUIPC = 3'b010,
      WB_MEM   = 3'b011,
      WB_LUI   = 3'b111
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks the addressed byte/halfword lane, extends it,
// and flags accesses that do not sit on their natural boundary.
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] i_raw,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data,
   output logic        o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_off)
         2'd0:    w_byte = i_raw[7:0];
         2'd1:    w_byte = i_raw[15:8];
         2'd2:    w_byte = i_raw[23:16];
         default: w_byte = i_raw[31:24];
      endcase
      w_half = i_off[1] ? i_raw[31:16] : i_raw[15:0];
   end

   always_comb begin
      o_data       = i_raw;
      o_misaligned = 1'b0;
      case (i_funct3)
         F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
         F3_LBU: o_data = {24'h0, w_byte};
         F3_LH: begin
            o_data       = {{16{w_half[15]}}, w_half};
            o_misaligned = i_off[0];
         end
         F3_LHU: begin
            o_data       = {16'h0, w_half};
            o_misaligned = i_off[0];
         end
         F3_LW:  o_misaligned = (i_off != 2'd0);
         // Unknown load sizes return the raw word and are treated as faulting.
         default: o_misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns load data at capture, qualifies the register
// write, honours stall/flush, and counts instructions retiring out of WB.
module mem_wb_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_alu_out,
   input  logic [XLEN-1:0]  in_mem_rdata,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rd,
   input  logic             in_reg_write,
   input  logic [2:0]       in_wb_sel,
   output logic             wb_valid,
   output logic [XLEN-1:0]  wb_pc,
   output logic [XLEN-1:0]  wb_imm,
   output logic [XLEN-1:0]  wb_alu_out,
   output logic [XLEN-1:0]  wb_mem_data,
   output logic [4:0]       wb_rd,
   output logic             wb_reg_write,
   output logic [2:0]       wb_sel,
   output logic             wb_load_misaligned,
   output logic [CNT_W-1:0] instret
);

   logic [31:0] w_align_data;
   logic        w_align_mis;
   logic        w_is_load;
   logic        w_mis;

   load_align u_load_align (
      .i_raw        (in_mem_rdata),
      .i_off        (in_alu_out[1:0]),
      .i_funct3     (in_funct3),
      .o_data       (w_align_data),
      .o_misaligned (w_align_mis)
   );

   assign w_is_load = (in_wb_sel == WB_MEM);
   assign w_mis     = in_valid & w_is_load & w_align_mis;

   logic             r_valid;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_imm;
   logic [XLEN-1:0]  r_alu_out;
   logic [XLEN-1:0]  r_mem_data;
   logic [4:0]       r_rd;
   logic             r_reg_write;
   logic [2:0]       r_sel;
   logic             r_mis;
   logic [CNT_W-1:0] r_instret;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_imm       <= '0;
         r_alu_out   <= '0;
         r_mem_data  <= '0;
         r_rd        <= '0;
         r_reg_write <= 1'b0;
         r_sel       <= '0;
         r_mis       <= 1'b0;
      end else if (!stall) begin
         r_valid     <= in_valid;
         r_pc        <= in_pc;
         r_imm       <= in_imm;
         r_alu_out   <= in_alu_out;
         r_mem_data  <= w_is_load ? w_align_data : in_mem_rdata;
         r_rd        <= in_rd;
         r_reg_write <= in_valid & in_reg_write & (in_rd != 5'd0) & ~w_mis;
         r_sel       <= in_wb_sel;
         r_mis       <= w_mis;
      end
   end

   // Counts the instruction leaving WB, so a stalled one is counted once; flush does not clear it.
   always_ff @(posedge clk) begin
      if (rst)
         r_instret <= '0;
      else if (r_valid && !stall)
         r_instret <= r_instret + CNT_W'(1);
   end

   assign wb_valid           = r_valid;
   assign wb_pc              = r_pc;
   assign wb_imm             = r_imm;
   assign wb_alu_out         = r_alu_out;
   assign wb_mem_data        = r_mem_data;
   assign wb_rd              = r_rd;
   assign wb_reg_write       = r_reg_write;
   assign wb_sel             = r_sel;
   assign wb_load_misaligned = r_mis;
   assign instret            = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load alignment, misalignment, stall/flush,
// write qualification and instret wrap (second instance with CNT_W=4).
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, in_valid, in_reg_write;
   logic [31:0] in_pc, in_imm, in_alu_out, in_mem_rdata;
   logic [2:0]  in_funct3, in_wb_sel;
   logic [4:0]  in_rd;

   logic        wb_valid, wb_reg_write, wb_load_misaligned;
   logic [31:0] wb_pc, wb_imm, wb_alu_out, wb_mem_data, instret;
   logic [4:0]  wb_rd;
   logic [2:0]  wb_sel;

   logic        s_valid, s_reg_write, s_mis;
   logic [31:0] s_pc, s_imm, s_alu_out, s_mem_data;
   logic [4:0]  s_rd;
   logic [2:0]  s_sel;
   logic [3:0]  s_instret;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_imm(in_imm), .in_alu_out(in_alu_out),
      .in_mem_rdata(in_mem_rdata), .in_funct3(in_funct3), .in_rd(in_rd),
      .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_imm(wb_imm), .wb_alu_out(wb_alu_out),
      .wb_mem_data(wb_mem_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .wb_sel(wb_sel), .wb_load_misaligned(wb_load_misaligned), .instret(instret)
   );

   mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_imm(in_imm), .in_alu_out(in_alu_out),
      .in_mem_rdata(in_mem_rdata), .in_funct3(in_funct3), .in_rd(in_rd),
      .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
      .wb_valid(s_valid), .wb_pc(s_pc), .wb_imm(s_imm), .wb_alu_out(s_alu_out),
      .wb_mem_data(s_mem_data), .wb_rd(s_rd), .wb_reg_write(s_reg_write),
      .wb_sel(s_sel), .wb_load_misaligned(s_mis), .instret(s_instret)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [31:0] raw, input logic [2:0] f3,
                        input logic [4:0] rd, input logic rw, input logic [2:0] sel);
      in_valid = v; in_pc = pc; in_imm = imm; in_alu_out = alu; in_mem_rdata = raw;
      in_funct3 = f3; in_rd = rd; in_reg_write = rw; in_wb_sel = sel;
   endtask

   task automatic check_flags(input string tag, input logic v, input logic rw,
                              input logic mis, input logic [31:0] ir);
      check({tag, ".valid"}, {31'b0, wb_valid}, {31'b0, v});
      check({tag, ".rw"}, {31'b0, wb_reg_write}, {31'b0, rw});
      check({tag, ".mis"}, {31'b0, wb_load_misaligned}, {31'b0, mis});
      check({tag, ".instret"}, instret, ir);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b1, $urandom, $urandom, $urandom, $urandom, 3'($urandom), 5'($urandom), 1'b1, 3'b011);

      for (int i = 0; i < 2; i++) begin
         step();
         check("rst.valid", {31'b0, wb_valid}, 32'd0);
         check("rst.pc", wb_pc, 32'd0);
         check("rst.imm", wb_imm, 32'd0);
         check("rst.alu", wb_alu_out, 32'd0);
         check("rst.mem", wb_mem_data, 32'd0);
         check("rst.rd", {27'b0, wb_rd}, 32'd0);
         check("rst.rw", {31'b0, wb_reg_write}, 32'd0);
         check("rst.sel", {29'b0, wb_sel}, 32'd0);
         check("rst.mis", {31'b0, wb_load_misaligned}, 32'd0);
         check("rst.instret", instret, 32'd0);
         check("rst.instret_s", {28'b0, s_instret}, 32'd0);
         drive(1'b1, $urandom, $urandom, $urandom, $urandom, 3'($urandom), 5'($urandom), 1'b1, 3'b001);
      end

      // ADD rd=3: first capture after reset release
      rst = 1'b0;
      drive(1'b1, 32'h100, 32'h0, 32'h55, 32'hDEADBEEF, 3'b000, 5'd3, 1'b1, 3'b001);
      step();
      check("add.pc", wb_pc, 32'h100);
      check("add.alu", wb_alu_out, 32'h55);
      check("add.mem_pass", wb_mem_data, 32'hDEADBEEF);
      check("add.rd", {27'b0, wb_rd}, 32'd3);
      check("add.sel", {29'b0, wb_sel}, 32'd1);
      check_flags("add", 1'b1, 1'b1, 1'b0, 32'd0);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h200 + i, 32'h9, 32'h77 + i, 32'h12345678, 3'b010, 5'd9, 1'b1, 3'b011);
         step();
         check("stall.pc", wb_pc, 32'h100);
         check("stall.alu", wb_alu_out, 32'h55);
         check("stall.rd", {27'b0, wb_rd}, 32'd3);
         check_flags("stall", 1'b1, 1'b1, 1'b0, 32'd0);
      end
      stall = 1'b0;

      drive(1'b1, 32'h300, 32'h0, 32'h1001, 32'h80FF7F01, 3'b000, 5'd7, 1'b1, 3'b011);
      step();
      check("lb1.data", wb_mem_data, 32'h0000007F);
      check("lb1.sel", {29'b0, wb_sel}, 32'd3);
      check_flags("lb1", 1'b1, 1'b1, 1'b0, 32'd1);

      drive(1'b1, 32'h304, 32'h0, 32'h1003, 32'h80FF7F01, 3'b000, 5'd7, 1'b1, 3'b011);
      step();
      check("lb3.data", wb_mem_data, 32'hFFFFFF80);
      check_flags("lb3", 1'b1, 1'b1, 1'b0, 32'd2);

      drive(1'b1, 32'h308, 32'h0, 32'h1003, 32'h80FF7F01, 3'b100, 5'd7, 1'b1, 3'b011);
      step();
      check("lbu3.data", wb_mem_data, 32'h00000080);
      check_flags("lbu3", 1'b1, 1'b1, 1'b0, 32'd3);

      drive(1'b1, 32'h30C, 32'h0, 32'h1002, 32'h80FF7F01, 3'b001, 5'd7, 1'b1, 3'b011);
      step();
      check("lh2.data", wb_mem_data, 32'hFFFF80FF);
      check_flags("lh2", 1'b1, 1'b1, 1'b0, 32'd4);

      drive(1'b1, 32'h310, 32'h0, 32'h2002, 32'h80FF7F01, 3'b010, 5'd5, 1'b1, 3'b011);
      step();
      check("lwmis.data", wb_mem_data, 32'h80FF7F01);
      check("lwmis.rd", {27'b0, wb_rd}, 32'd5);
      check_flags("lwmis", 1'b1, 1'b0, 1'b1, 32'd5);

      drive(1'b1, 32'h314, 32'h0, 32'h2001, 32'h80FF7F01, 3'b001, 5'd5, 1'b1, 3'b011);
      step();
      check_flags("lhmis", 1'b1, 1'b0, 1'b1, 32'd6);

      drive(1'b1, 32'h318, 32'h0, 32'h42, 32'hCAFEF00D, 3'b000, 5'd0, 1'b1, 3'b001);
      step();
      check("x0.mem_pass", wb_mem_data, 32'hCAFEF00D);
      check_flags("x0", 1'b1, 1'b0, 1'b0, 32'd7);

      drive(1'b1, 32'h31C, 32'h12345000, 32'h2001, 32'h80FF7F01, 3'b001, 5'd4, 1'b1, 3'b111);
      step();
      check("lui.sel", {29'b0, wb_sel}, 32'd7);
      check("lui.imm", wb_imm, 32'h12345000);
      check("lui.mem_pass", wb_mem_data, 32'h80FF7F01);
      check_flags("lui", 1'b1, 1'b1, 1'b0, 32'd8);

      stall = 1'b1; flush = 1'b1;
      drive(1'b1, 32'h320, 32'h0, 32'h10, 32'h1, 3'b000, 5'd6, 1'b1, 3'b001);
      step();
      check("sflush.pc", wb_pc, 32'd0);
      check_flags("sflush", 1'b0, 1'b0, 1'b0, 32'd8);
      stall = 1'b0; flush = 1'b0;

      drive(1'b1, 32'h324, 32'h0, 32'h3000, 32'hA5A5_5A5A, 3'b010, 5'd8, 1'b1, 3'b011);
      step();
      check("lw.data", wb_mem_data, 32'hA5A55A5A);
      check_flags("lw", 1'b1, 1'b1, 1'b0, 32'd8);

      drive(1'b0, 32'h328, 32'h0, 32'h0, 32'h0, 3'b000, 5'd8, 1'b1, 3'b001);
      step();
      check_flags("bubble", 1'b0, 1'b0, 1'b0, 32'd9);

      // Wrap test: 17 back-to-back retirements on the 4-bit counter
      rst = 1'b1;
      step();
      check("wrap.rst_s", {28'b0, s_instret}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 32'h400 + 32'(i) * 4, 32'h0, 32'h0, 32'h0, 3'b000, 5'd1, 1'b1, 3'b001);
         step();
      end
      check("wrap.mid_s", {28'b0, s_instret}, 32'd0);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 3'b001);
      step();
      check("wrap.small", {28'b0, s_instret}, 32'd1);
      check("wrap.big", instret, 32'd17);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
